// File: rtl/mem_responder.sv
// mem_responder: wait-state memory responder for the CPU data/instruction bus.
// One request at a time via req/ack; response after WAIT_CYCLES extra cycles.
// Optional feature macro: MEM_RESP_SUBWORD_EN (half/byte accesses). When it is
// undefined, size is ignored and every access is treated as a word access.
module mem_responder #(
  parameter int unsigned ADDR_BITS   = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err,
  output logic        busy
);

  localparam int unsigned DEPTH   = 1 << ADDR_BITS;
  localparam bit          NO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0]  LOAD    = NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, next_state;
  logic [3:0]  cnt, next_cnt;

  logic        h_we;
  logic [31:0] h_addr, h_wdata;
  logic [1:0]  h_size;

  logic        e_we;
  logic [31:0] e_addr, e_wdata;
  logic [1:0]  e_size, sz;

  logic                 go_resp, acc_err, misaligned, out_of_range, wr_en;
  logic [ADDR_BITS-1:0] idx;
  logic [31:0]          rd_word, wr_word, rsp_data;

  logic [31:0] mem [DEPTH];

  // Next-state and wait counter sequencing.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          if (NO_WAIT) begin
            next_state = RESP;
          end else begin
            next_state = WAIT;
            next_cnt   = LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) next_state = RESP;
        else             next_cnt   = cnt - 4'd1;
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // With zero wait states the commit edge is the acceptance edge, so the
  // live bus fields stand in for the not-yet-latched holding registers.
  always_comb begin
    if (state == IDLE) begin
      e_we    = we;
      e_addr  = addr;
      e_wdata = wdata;
      e_size  = size;
    end else begin
      e_we    = h_we;
      e_addr  = h_addr;
      e_wdata = h_wdata;
      e_size  = h_size;
    end
  end

`ifdef MEM_RESP_SUBWORD_EN
  assign sz = e_size;
`else
  logic unused_size;
  assign unused_size = ^e_size;
  assign sz = 2'b00;
`endif

  // Access checks and lane selection on the effective request.
  always_comb begin
    out_of_range = (e_addr >> (ADDR_BITS + 2)) != 32'd0;
    case (sz)
      2'b00:   misaligned = (e_addr[1:0] != 2'b00);
      2'b01:   misaligned = e_addr[0];
      2'b10:   misaligned = 1'b0;
      default: misaligned = 1'b1;
    endcase
    acc_err = out_of_range || misaligned;
    idx     = e_addr[ADDR_BITS+1:2];
    rd_word = mem[idx];

    rsp_data = rd_word;
    wr_word  = rd_word;
    case (sz)
      2'b00: wr_word = e_wdata;
      2'b01: begin
        rsp_data = {16'h0000, rd_word[{e_addr[1], 4'b0000} +: 16]};
        wr_word[{e_addr[1], 4'b0000} +: 16] = e_wdata[15:0];
      end
      2'b10: begin
        rsp_data = {24'h000000, rd_word[{e_addr[1:0], 3'b000} +: 8]};
        wr_word[{e_addr[1:0], 3'b000} +: 8] = e_wdata[7:0];
      end
      default: ;
    endcase
  end

  assign go_resp = (next_state == RESP) && (state != RESP);
  assign wr_en   = go_resp && e_we && !acc_err && reset;

  // Control state, holding registers and registered response outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      h_we    <= 1'b0;
      h_addr  <= '0;
      h_wdata <= '0;
      h_size  <= '0;
      ack     <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
      busy    <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      if (state == IDLE && req) begin
        h_we    <= we;
        h_addr  <= addr;
        h_wdata <= wdata;
        h_size  <= size;
      end
      ack  <= go_resp;
      busy <= (next_state != IDLE);
      if (go_resp) begin
        err   <= acc_err;
        rdata <= (acc_err || e_we) ? '0 : rsp_data;
      end
    end
  end

  // Word array; contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (wr_en) mem[idx] <= wr_word;
  end

endmodule
